// File: rtl/ws2812_frame_encoder.sv
// ws2812_frame_encoder: serialises 24-bit pixels MSB-first onto a WS2812 data line
// Ports:
//   i_clk          clock
//   i_rst          synchronous reset, active-high
//   i_pixel        pixel word, sent MSB first
//   i_pixel_valid  i_pixel is valid
//   i_pixel_last   accepted pixel closes the frame (latch interval follows)
//   o_pixel_ready  encoder can accept a pixel this cycle
//   o_serial       WS2812 data line
//   o_busy         frame open or latching
//   o_underrun     sticky mid-frame gap flag (only with LED_ENC_UNDERRUN_EN)
// Optional feature macro: LED_ENC_UNDERRUN_EN enables the gap monitor and o_underrun.
module ws2812_frame_encoder #(
    parameter int T0H_CYC     = 40,
    parameter int T1H_CYC     = 80,
    parameter int BIT_CYC     = 125,
    parameter int RESET_CYC   = 5000,
    parameter int GAP_MAX_CYC = 2500
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_pixel,
    input  logic        i_pixel_valid,
    input  logic        i_pixel_last,
    output logic        o_pixel_ready,
    output logic        o_serial,
`ifdef LED_ENC_UNDERRUN_EN
    output logic        o_busy,
    output logic        o_underrun
`else
    output logic        o_busy
`endif
);
    localparam int MAX_CYC = BIT_CYC > RESET_CYC ? BIT_CYC : RESET_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] T0H = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H = CW'(T1H_CYC);
    localparam logic [CW-1:0] L0 = CW'(BIT_CYC - T0H_CYC);
    localparam logic [CW-1:0] L1 = CW'(BIT_CYC - T1H_CYC);
    localparam logic [CW-1:0] RST = CW'(RESET_CYC);

    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
          RESET_CYC >= BIT_CYC && GAP_MAX_CYC > 0)) begin : g_bad_params
        $error("ws2812_frame_encoder: illegal timing parameters");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [23:0]    shreg_q, shreg_d;
    logic [4:0]     bit_idx_q, bit_idx_d;
    logic           last_q, last_d;
    logic           frame_open_q, frame_open_d;
    logic           serial_q, serial_d;
    logic           slot_end;
    logic           accept;

    always_comb begin
        slot_end      = cnt_q == CW'(1);
        // the final LOW cycle of a non-last pixel doubles as an accept slot so pixels chain without a gap
        o_pixel_ready = state_q == IDLE ||
                        (state_q == LOW && slot_end && bit_idx_q == 5'd0 && !last_q);
        accept        = i_pixel_valid && o_pixel_ready;
        state_d       = state_q;
        cnt_d         = state_q == IDLE ? '0 : cnt_q - CW'(1);
        shreg_d       = shreg_q;
        bit_idx_d     = bit_idx_q;
        last_d        = last_q;
        frame_open_d  = frame_open_q;
        case (state_q)
            HIGH: if (slot_end) begin
                state_d = LOW;
                cnt_d   = shreg_q[23] ? L1 : L0;
            end
            LOW: if (slot_end) begin
                if (bit_idx_q != 5'd0) begin
                    state_d   = HIGH;
                    shreg_d   = shreg_q << 1;
                    bit_idx_d = bit_idx_q - 5'd1;
                    cnt_d     = shreg_q[22] ? T1H : T0H;
                end else begin
                    state_d = last_q ? LATCH : IDLE;
                    cnt_d   = last_q ? RST : '0;
                end
            end
            LATCH: if (slot_end) begin
                state_d      = IDLE;
                frame_open_d = 1'b0;
            end
            default: ;
        endcase
        if (accept) begin
            state_d      = HIGH;
            shreg_d      = i_pixel;
            bit_idx_d    = 5'd23;
            last_d       = i_pixel_last;
            frame_open_d = 1'b1;
            cnt_d        = i_pixel[23] ? T1H : T0H;
        end
        // registered so the line never glitches on state-decode transitions
        serial_d = state_d == HIGH;
        o_serial = serial_q;
        o_busy   = frame_open_q || state_q != IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            last_q       <= 1'b0;
            frame_open_q <= 1'b0;
            serial_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            last_q       <= last_d;
            frame_open_q <= frame_open_d;
            serial_q     <= serial_d;
        end
    end

`ifdef LED_ENC_UNDERRUN_EN
    localparam int GW = $clog2(GAP_MAX_CYC + 1);

    logic [GW-1:0] gap_q, gap_d;
    logic          underrun_q, underrun_d;

    always_comb begin
        // saturates at the limit so a long stall cannot wrap and re-trigger
        gap_d      = accept ? '0 :
                     (state_q == IDLE && frame_open_q && gap_q != GW'(GAP_MAX_CYC)) ? gap_q + GW'(1) : gap_q;
        underrun_d = underrun_q || gap_d == GW'(GAP_MAX_CYC);
        o_underrun = underrun_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gap_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            gap_q      <= gap_d;
            underrun_q <= underrun_d;
        end
    end
`endif
endmodule

// File: tb/tb_ws2812_frame_encoder.sv
// tb_ws2812_frame_encoder: random and directed pixel streams checked cycle-by-cycle against a waveform model
module tb_ws2812_frame_encoder;
    localparam int T0H  = 40;
    localparam int T1H  = 80;
    localparam int BITC = 125;
    localparam int RSTC = 5000;
    localparam int FULL = 24 * BITC + RSTC + 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] pixel = '0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        ready, serial, busy;

    int vectors = 0;
    int errors = 0;
    bit q[$];
    bit open_m = 1'b0;
    bit tail_latch = 1'b0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ws2812_frame_encoder dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_pixel(pixel),
        .i_pixel_valid(valid),
        .i_pixel_last(last),
        .o_pixel_ready(ready),
        .o_serial(serial),
        .o_busy(busy)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return q.size() == 0 || (q.size() == 1 && !tail_latch);
    endfunction

    task automatic push_pixel(logic [23:0] p, bit l);
        for (int b = 23; b >= 0; b--)
            for (int c = 0; c < BITC; c++)
                q.push_back(c < (p[b] ? T1H : T0H));
        if (l)
            for (int c = 0; c < RSTC; c++)
                q.push_back(1'b0);
        open_m     = !l;
        tail_latch = l;
    endtask

    task automatic step();
        bit acc;
        @(negedge clk);
        if (chk_en) begin
            check("serial", serial, q.size() != 0 ? q[0] : 1'b0);
            check("ready", ready, exp_ready());
            check("busy", busy, q.size() != 0 || open_m);
        end
        acc = valid && exp_ready() && !rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            open_m     = 1'b0;
            tail_latch = 1'b0;
        end else begin
            if (q.size() != 0) void'(q.pop_front());
            if (acc) push_pixel(pixel, last);
        end
        #1;
    endtask

    task automatic send(logic [23:0] p, bit l);
        int n = 0;
        bit done = 1'b0;
        pixel = p;
        last  = l;
        valid = 1'b1;
        while (!done && n < 20000) begin
            done = exp_ready();
            step();
            n++;
        end
        if (!done) check("accept_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic idle(int n);
        valid = 1'b0;
        repeat (n) begin
            pixel = 24'($urandom);
            last  = 1'($urandom);
            step();
        end
    endtask

    initial begin
        int np;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk_en = 1'b1;
        idle(1000);
        send(24'hFF00FF, 1'b1);
        idle(FULL);
        send(24'hA5A5A5, 1'b0);
        send(24'h000001, 1'b1);
        idle(FULL);
        send(24'h123456, 1'b1);
        idle(10 * BITC + 50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);
        send(24'h00FF00, 1'b1);
        idle(FULL);
        repeat (2) begin
            np = 1 + int'($urandom_range(0, 2));
            for (int i = 0; i < np; i++) begin
                if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 20)));
                send(24'($urandom), i == np - 1);
            end
            idle(FULL);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, %0d vectors %0d miscompares", vectors, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ws2812_frame_encoder.md
Name: ws2812_frame_encoder

Overview:
Upstream driver for the `led` chain. Accepts 24-bit pixel words over a valid/ready handshake and bit-bangs them MSB-first onto a single serial line with WS2812 nominal timing. After the frame's last pixel it holds the line low for the latch (reset) interval. Its `o_serial` drives `i_serial` of the first `led` instance.

Parameters:
- T0H_CYC, 40: high time of a '0' bit, in i_clk cycles (400 ns at 100 MHz).
- T1H_CYC, 80: high time of a '1' bit, in cycles (800 ns).
- BIT_CYC, 125: total bit slot, in cycles (1.25 us).
- RESET_CYC, 5000: low latch interval after the last pixel, in cycles (50 us).
- GAP_MAX_CYC, 2500: mid-frame idle limit before underrun is flagged. Used only with LED_ENC_UNDERRUN_EN.
- Legal range: 0 < T0H_CYC < T1H_CYC < BIT_CYC; RESET_CYC >= BIT_CYC. Violations are elaborate-time errors.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_pixel  in  24  pixel word, sent MSB first.
- i_pixel_valid  in  1  i_pixel is valid.
- i_pixel_last  in  1  qualifies the accepted pixel as the last of its frame.
- o_pixel_ready  out  1  encoder can accept a pixel this cycle.
- o_serial  out  1  WS2812 data line to the `led` chain.
- o_busy  out  1  high while a frame is open or latching.
- o_underrun  out  1  sticky underrun flag. Present only with LED_ENC_UNDERRUN_EN.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_serial=0, o_pixel_ready=1, o_busy=0, o_underrun=0. State=IDLE, frame_open=0, all counters 0.
- Reset mid-operation: everything above takes effect on the next i_clk edge. The partial bit is truncated, the line drops low, and no latch interval is inserted.
- Accept: a pixel is taken when i_pixel_valid && o_pixel_ready at an i_clk edge. The encoder loads a 24-bit shift register and bit_idx=23, samples last_q=i_pixel_last, sets frame_open=1, and enters HIGH.
- Latency: o_serial rises on the first cycle after the accept edge.
- States: IDLE, HIGH, LOW, LATCH.
  - HIGH: o_serial=1 for T1H_CYC cycles if the current bit is 1, else T0H_CYC cycles. Then go to LOW.
  - LOW: o_serial=0 for BIT_CYC minus the high time, so every slot is exactly BIT_CYC cycles.
  - At the end of LOW with bit_idx>0: shift left, decrement bit_idx, return to HIGH.
  - At the end of LOW with bit_idx==0 and last_q=1: go to LATCH.
  - At the end of LOW with bit_idx==0 and last_q=0: go to IDLE with frame_open kept at 1.
  - LATCH: o_serial=0 for RESET_CYC cycles, then IDLE with frame_open=0.
- o_pixel_ready is asserted:
  - in IDLE, or
  - on the final LOW cycle of bit 0 when last_q=0.
- Seamless chaining: an accept on that final LOW cycle goes straight to HIGH of the new pixel with no gap cycle.
- o_pixel_ready is 0 in HIGH, in LATCH, and in all other LOW cycles.
- o_busy = frame_open or state != IDLE.
- i_pixel_last is ignored unless the pixel is accepted in that cycle.
- Counters: one slot counter sized $clog2(max(BIT_CYC,RESET_CYC)+1). It is reloaded on each state entry and counts down to 1.
- Empty frame: there is none. Latching only ever follows a pixel marked last.
- No valid input in IDLE: the line stays low indefinitely and no latch is generated automatically.

Optional Feature:
- Macro: LED_ENC_UNDERRUN_EN.
- Defined:
  - A gap counter runs while state=IDLE and frame_open=1.
  - When the gap reaches GAP_MAX_CYC cycles, o_underrun goes 1 and stays 1 until i_rst. The frame continues normally.
  - The gap counter clears on each accept.
- Undefined: the o_underrun port and the gap counter are absent. Mid-frame gaps are unmonitored.

Test Plan:
- Single pixel 24'hFF00FF with last=1 after reset → 24 slots of 125 cycles each. High widths are 8×80, 8×40, 8×80. The line is then low for 5000 cycles, after which ready=1 and busy=0.
- Back-to-back 24'hA5A5A5 then 24'h000001(last), valid held high → 48 contiguous slots with no extra cycle between pixels. Ready pulses for exactly 1 cycle at the pixel boundary, then the latch follows.
- valid low for 1000 cycles after reset → o_serial=0, busy=0, ready=1 throughout.
- i_rst asserted during bit 10 of a pixel → next cycle o_serial=0, ready=1, busy=0. A following pixel 24'h00FF00(last) encodes correctly.
- Loopback into `led`: send 24'hFF00FF(last) → `led` o_led_data==24'hFF00FF after the latch.
- LED_ENC_UNDERRUN_EN with pixel(last=0), then valid withheld for 2500 cycles → o_underrun=1 on the 2500th gap cycle and stays set. Without the macro, the same stimulus compiles and the serial output is unchanged.
